// File: rtl/dds_phase2amp_if.sv
// Stream bundle for the phase-to-amplitude converter: phase words and offset in,
// packed {cos, sin} samples out.
interface dds_phase2amp_if #(
   parameter int PHASE_WIDTH = 14,
   parameter int OUT_WIDTH   = 16
);
   logic [PHASE_WIDTH-1:0] phase_offset;
   logic [15:0]            S_AXIS_PHASE_tdata;
   logic                   S_AXIS_PHASE_tvalid;
   logic                   S_AXIS_PHASE_tready;
   logic [2*OUT_WIDTH-1:0] M_AXIS_DATA_tdata;
   logic                   M_AXIS_DATA_tvalid;
   logic                   M_AXIS_DATA_tready;

   modport master (
      output phase_offset, S_AXIS_PHASE_tdata, S_AXIS_PHASE_tvalid, M_AXIS_DATA_tready,
      input  S_AXIS_PHASE_tready, M_AXIS_DATA_tdata, M_AXIS_DATA_tvalid
   );

   modport slave (
      input  phase_offset, S_AXIS_PHASE_tdata, S_AXIS_PHASE_tvalid, M_AXIS_DATA_tready,
      output S_AXIS_PHASE_tready, M_AXIS_DATA_tdata, M_AXIS_DATA_tvalid
   );
endinterface

// File: rtl/dds_phase2amp.sv
// Phase-to-amplitude converter: offset add, quarter-wave ROM lookup with symmetry
// folding, and sign restore, as a 3-stage pipeline with one global stall.
module dds_phase2amp #(
   parameter int PHASE_WIDTH = 14,
   parameter int OUT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   dds_phase2amp_if.slave       bus
);
   localparam int ADDR_WIDTH = PHASE_WIDTH - 2;
   localparam int ROM_DEPTH  = 1 << ADDR_WIDTH;
   localparam int AMP_MAX    = (1 << (OUT_WIDTH - 1)) - 1;

   // Half-LSB-offset quarter sine, evaluated at elaboration by Taylor series.
   function automatic logic [OUT_WIDTH-2:0] rom_entry(input int k);
      real x;
      real term;
      real acc;
      int  r;
      x    = 1.5707963267948966 * (real'(k) + 0.5) / real'(ROM_DEPTH);
      term = x;
      acc  = x;
      for (int n = 1; n < 16; n++) begin
         term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
         acc  = acc + term;
      end
      r = $rtoi(acc * real'(AMP_MAX) + 0.5);
      rom_entry = r[OUT_WIDTH-2:0];
   endfunction

   logic [OUT_WIDTH-2:0] rom_s [ROM_DEPTH];

   for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
      localparam logic [OUT_WIDTH-2:0] ENTRY = rom_entry(k);
      assign rom_s[k] = ENTRY;
   end

   logic                   adv_s;
   logic                   accept_s;
   logic [PHASE_WIDTH-1:0] phase_s;
   logic                   unused_s;

   logic                   v1_q, v1_d;
   logic [1:0]             quad1_q, quad1_d;
   logic [ADDR_WIDTH-1:0]  idx1_q, idx1_d;
   logic                   v2_q, v2_d;
   logic [OUT_WIDTH-2:0]   sin_mag2_q, sin_mag2_d;
   logic [OUT_WIDTH-2:0]   cos_mag2_q, cos_mag2_d;
   logic                   sin_neg2_q, sin_neg2_d;
   logic                   cos_neg2_q, cos_neg2_d;
   logic                   v3_q, v3_d;
   logic [OUT_WIDTH-1:0]   sin3_q, sin3_d;
   logic [OUT_WIDTH-1:0]   cos3_q, cos3_d;

   assign unused_s = ^bus.S_AXIS_PHASE_tdata[15:PHASE_WIDTH];

   // Next-state logic for all three stages; everything holds while adv_s is low.
   always_comb begin
      adv_s      = !v3_q || bus.M_AXIS_DATA_tready;
      accept_s   = bus.S_AXIS_PHASE_tvalid && adv_s;
      phase_s    = bus.S_AXIS_PHASE_tdata[PHASE_WIDTH-1:0] + bus.phase_offset;
      v1_d       = v1_q;
      quad1_d    = quad1_q;
      idx1_d     = idx1_q;
      v2_d       = v2_q;
      sin_mag2_d = sin_mag2_q;
      cos_mag2_d = cos_mag2_q;
      sin_neg2_d = sin_neg2_q;
      cos_neg2_d = cos_neg2_q;
      v3_d       = v3_q;
      sin3_d     = sin3_q;
      cos3_d     = cos3_q;
      if (adv_s) begin
         v1_d = accept_s;
         if (accept_s) begin
            quad1_d = phase_s[PHASE_WIDTH-1:PHASE_WIDTH-2];
            idx1_d  = phase_s[ADDR_WIDTH-1:0];
         end else begin
            quad1_d = quad1_q;
            idx1_d  = idx1_q;
         end
         // Odd quadrants mirror the index; sign follows the quadrant's half-plane.
         v2_d       = v1_q;
         sin_mag2_d = quad1_q[0] ? rom_s[~idx1_q] : rom_s[idx1_q];
         cos_mag2_d = quad1_q[0] ? rom_s[idx1_q]  : rom_s[~idx1_q];
         sin_neg2_d = quad1_q[1];
         cos_neg2_d = quad1_q[1] ^ quad1_q[0];
         v3_d       = v2_q;
         sin3_d     = sin_neg2_q ? ({OUT_WIDTH{1'b0}} - {1'b0, sin_mag2_q}) : {1'b0, sin_mag2_q};
         cos3_d     = cos_neg2_q ? ({OUT_WIDTH{1'b0}} - {1'b0, cos_mag2_q}) : {1'b0, cos_mag2_q};
      end else begin
         v1_d = v1_q;
      end
   end

   // Pipeline registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q       <= 1'b0;
         quad1_q    <= 2'b00;
         idx1_q     <= {ADDR_WIDTH{1'b0}};
         v2_q       <= 1'b0;
         sin_mag2_q <= {(OUT_WIDTH-1){1'b0}};
         cos_mag2_q <= {(OUT_WIDTH-1){1'b0}};
         sin_neg2_q <= 1'b0;
         cos_neg2_q <= 1'b0;
         v3_q       <= 1'b0;
         sin3_q     <= {OUT_WIDTH{1'b0}};
         cos3_q     <= {OUT_WIDTH{1'b0}};
      end else begin
         v1_q       <= v1_d;
         quad1_q    <= quad1_d;
         idx1_q     <= idx1_d;
         v2_q       <= v2_d;
         sin_mag2_q <= sin_mag2_d;
         cos_mag2_q <= cos_mag2_d;
         sin_neg2_q <= sin_neg2_d;
         cos_neg2_q <= cos_neg2_d;
         v3_q       <= v3_d;
         sin3_q     <= sin3_d;
         cos3_q     <= cos3_d;
      end
   end

   assign bus.S_AXIS_PHASE_tready = adv_s;
   assign bus.M_AXIS_DATA_tvalid  = v3_q;
   assign bus.M_AXIS_DATA_tdata   = {cos3_q, sin3_q};
endmodule
